accum_drain: RTL
================

# accum_drain

Output-side consumer of the row accumulator. Tracks the accumulator's fixed 3-cycle pipeline latency with a valid/last delay line and captures the DP-lane summed output when it becomes valid. Each lane is requantized (round, ReLU, saturate), buffered in a 2-entry word FIFO, and serialized onto a narrow valid/ready stream toward the feature-map write path.

## Interface
- DW, 32, accumulator lane width (signed two's complement)
- DP, 56, lanes per accumulator word
- LAT, 3, accumulator latency in cycles (equal to its stage count)
- LANES, 8, lanes per output beat; DP must be a multiple of LANES
- OUT_DW, 8, requantized lane width (unsigned)
- SHIFT, 8, requantization right shift; 1 ≤ SHIFT < DW
- clk  in  1  clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  pulse in the same cycle the first row's partial sums enter the accumulator
- in_last  in  1  tag for that issue: final word of an output row; sampled only with in_valid
- acc_i  in  DW*DP  accumulator output bus; lane m at [DW*m +: DW]
- out_data  out  OUT_DW*LANES  beat data; lane j of beat b is source lane b*LANES+j
- out_valid  out  1  beat valid
- out_ready  in  1  downstream accept
- out_last  out  1  high on the final beat of a word tagged in_last
- busy  out  1  high if the delay line, FIFO, or serializer holds anything
- overflow  out  1  sticky: a captured word was dropped because the FIFO was full

## Operation
- Delay line: LAT-deep shift register of {valid, last}. An in_valid at cycle t yields cap_en during cycle t+LAT. On that cycle acc_i is sampled and requantized.
- Requantize per lane, with x signed DW:
  - y = (x + 2^(SHIFT-1)) >>> SHIFT, computed at DW+1 bits so the add cannot wrap.
  - If y < 0, output 0.
  - Else if y > 2^OUT_DW−1, output 2^OUT_DW−1.
  - Else output y[OUT_DW-1:0].
- FIFO: 2 entries of {OUT_DW*DP data, last}.
  - Push on cap_en when not full.
  - If cap_en occurs while full and no pop happens that cycle, the word is dropped and overflow is set. overflow clears only on rst.
  - cap_en and pop in the same cycle while full: the push is accepted and there is no overflow.
- Serializer operates on the FIFO head. Beat counter runs 0..DP/LANES−1.
  - out_valid = FIFO not empty.
  - out_data = head lanes [beat*LANES +: LANES].
  - out_last = head.last && beat == DP/LANES−1.
- Handshake:
  - A beat transfers when out_valid && out_ready.
  - On a transfer of a non-final beat, the counter increments.
  - On a transfer of the final beat, the counter returns to 0 and the head pops.
  - While out_valid is high and out_ready is low, out_data and out_last are held stable.
- States are implicit: IDLE (empty), STREAM (non-empty, beat < final), LAST_BEAT (final beat presented). A pop that leaves a second word in the FIFO goes straight to STREAM with beat 0 and no bubble.
- Reset values: out_valid 0, out_last 0, out_data 0, busy 0, overflow 0. Beat counter, FIFO pointers and delay line all 0.

## Timing
- Capture latency: in_valid at t, capture at the edge ending t+LAT, out_valid high in t+LAT+1. With defaults this is 4 cycles after in_valid.
- One word drains in DP/LANES = 7 cycles with out_ready held high. The sustained rate is one issue per 7 cycles; faster issue fills the FIFO and then overflows.
- Back-to-back issues one cycle apart are each tracked independently by the delay line.
- rst asserted mid-stream: at the next edge all state clears. In-flight delay-line entries and FIFO words are discarded. out_valid is low the cycle after rst.
- in_last without in_valid is ignored.
- busy is combinational from state. It drops in the cycle after the final pop when the delay line is empty.

## Test plan
- Single word: all lanes = 0x00000180, SHIFT 8, in_valid at cycle 10 → out_valid at 14. 7 beats, each lane 0x02 (0x180 + 0x80 = 0x200, >>8 = 2). out_last low.
- Quantization edges on lanes 0..4:
  - −1 → 0x00
  - 0x7F → 0x00
  - 0x80 → 0x01
  - 0x0000FF7F → 0xFF
  - 0x7FFFFFFF → 0xFF (saturate, no wrap)
- Backpressure: out_ready low for 5 cycles on beat 3 → beat 3 data held stable. Exactly 7 transfers occur in total, with no duplicated or skipped beat.
- Overflow: 4 issues 1 cycle apart with out_ready low → words 1 and 2 are stored, words 3 and 4 are dropped, overflow = 1. Then releasing out_ready drains exactly 14 beats.
- Last tagging: two issues, the second with in_last → out_last high only on beat 6 of word 2.
- Reset: rst pulsed during beat 2 of word 1 with word 2 queued → out_valid 0 the next cycle, busy 0, overflow 0. A fresh issue after reset behaves as in the single-word test.

Source files
------------

// File: rtl/accum_drain.sv
// accum_drain: tracks accumulator latency, requantizes captured words into a 2-deep FIFO and serializes LANES-wide beats (in_valid/in_last/acc_i in; out_data/out_valid/out_last/out_ready stream; busy, sticky overflow)
module accum_drain #(
  parameter int DW     = 32,
  parameter int DP     = 56,
  parameter int LAT    = 3,
  parameter int LANES  = 8,
  parameter int OUT_DW = 8,
  parameter int SHIFT  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic                    in_last,
  input  logic [DW*DP-1:0]        acc_i,
  output logic [OUT_DW*LANES-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    busy,
  output logic                    overflow
);
  localparam int NB = DP / LANES;
  localparam int BW = NB > 1 ? $clog2(NB) : 1;
  localparam int WW = OUT_DW * DP;
  localparam int BTW = OUT_DW * LANES;
  localparam logic [BW-1:0] LB = BW'(NB - 1);
  localparam logic [DW:0] RND = (DW + 1)'(1) << (SHIFT - 1);
  logic [LAT-1:0] dv, dl;
  logic [WW-1:0] q;
  logic [WW-1:0] mem [2];
  logic [1:0] ml, cnt;
  logic wp, rp, cap, full, empty, fin, pop, push;
  logic [BW-1:0] beat;
  for (genvar i = 0; i < DP; i++) begin : g_q
    logic signed [DW:0] s, y;
    assign s = {acc_i[DW*i+DW-1], acc_i[DW*i +: DW]} + RND;
    assign y = s >>> SHIFT;
    assign q[OUT_DW*i +: OUT_DW] = y[DW] ? '0 : (|y[DW-1:OUT_DW]) ? '1 : y[OUT_DW-1:0];
  end
  always_comb begin
    cap = dv[LAT-1];
    empty = cnt == 2'd0;
    full = cnt[1];
    fin = beat == LB;
    out_valid = !empty;
    pop = out_valid & out_ready & fin;
    push = cap & (!full | pop);
    out_data = empty ? '0 : mem[rp][beat*BTW +: BTW];
    out_last = !empty & ml[rp] & fin;
    busy = (|dv) | !empty;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      dv <= '0;
      dl <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      cnt <= 2'd0;
      beat <= '0;
      overflow <= 1'b0;
    end else begin
      dv <= LAT'({dv, in_valid});
      dl <= LAT'({dl, in_valid & in_last});
      if (push) wp <= ~wp;
      if (pop) rp <= ~rp;
      cnt <= cnt + 2'(push) - 2'(pop);
      if (out_valid && out_ready) beat <= fin ? '0 : beat + 1'b1;
      if (cap && full && !pop) overflow <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wp] <= q;
      ml[wp] <= dl[LAT-1];
    end
  end
endmodule
